// File: rtl/bbs_pkg.sv
// rtl/bbs_pkg.sv - shared types and modular helpers for the BBS random stream
package bbs_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SQ   = 1'b1
    } bbs_state_t;

    // Widest datapath the reduction helper supports (N_BITS + 1 for N_BITS <= 32).
    localparam int MAX_W = 33;

    function automatic logic [MAX_W-1:0] mod_add_sub(input logic [MAX_W-1:0] value,
                                                     input logic [MAX_W-1:0] modulus);
        return (value >= modulus) ? (value - modulus) : value;
    endfunction

    function automatic int word_iters(input int out_bits, input int bits_per_iter);
        return out_bits / bits_per_iter;
    endfunction

endpackage

// File: rtl/bbs_rng_stream_if.sv
// rtl/bbs_rng_stream_if.sv - seed offer and random word stream bundle
interface bbs_rng_stream_if #(
    parameter int N_BITS   = 20,
    parameter int OUT_BITS = 8
);
    logic                seed_valid;
    logic                seed_ready;
    logic [N_BITS-1:0]   seed;
    logic                seed_err;
    logic                rnd_valid;
    logic                rnd_ready;
    logic [OUT_BITS-1:0] rnd_data;

    modport master (
        output seed_valid, seed, rnd_ready,
        input  seed_ready, seed_err, rnd_valid, rnd_data
    );

    modport slave (
        input  seed_valid, seed, rnd_ready,
        output seed_ready, seed_err, rnd_valid, rnd_data
    );
endinterface

// File: rtl/bbs_modsq_serial.sv
// rtl/bbs_modsq_serial.sv - bit-serial interleaved a*a mod MODULUS in N_BITS cycles
module bbs_modsq_serial
    import bbs_pkg::*;
#(
    parameter int N_BITS  = 20,
    parameter int MODULUS = 272953
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [N_BITS-1:0] a,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] result
);

    localparam int DW = N_BITS + 1;
    localparam int IW = $clog2(N_BITS);
    localparam logic [DW-1:0] MOD_W = DW'(MODULUS);

    logic [N_BITS-1:0] r_q;
    logic [N_BITS-1:0] a_q;
    logic [IW-1:0]     idx_q;
    logic              active_q;

    logic [DW-1:0]     dbl;
    logic [DW-1:0]     dbl_red;
    logic [DW-1:0]     acc;
    logic [N_BITS-1:0] acc_red;

    // Horner step, MSB first: r = 2r mod M, then r = r + a mod M when the scanned bit is set.
    always_comb begin
        dbl     = {r_q, 1'b0};
        dbl_red = DW'(mod_add_sub(MAX_W'(dbl), MAX_W'(MOD_W)));
        acc     = a_q[idx_q] ? (dbl_red + {1'b0, a_q}) : dbl_red;
        acc_red = N_BITS'(mod_add_sub(MAX_W'(acc), MAX_W'(MOD_W)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q      <= '0;
            a_q      <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (start && !active_q) begin
            r_q      <= '0;
            a_q      <= a;
            idx_q    <= IW'(N_BITS - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            r_q <= acc_red;
            if (idx_q == '0) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

    assign busy   = active_q;
    assign done   = active_q && (idx_q == '0);
    assign result = acc_red;

endmodule

// File: rtl/bbs_rng_stream.sv
// rtl/bbs_rng_stream.sv - Blum Blum Shub generator packing harvested LSBs into a word stream
module bbs_rng_stream
    import bbs_pkg::*;
#(
    parameter int N_BITS        = 20,
    parameter int MODULUS       = 272953,
    parameter int OUT_BITS      = 8,
    parameter int BITS_PER_ITER = 1,
    parameter int DEFAULT_SEED  = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    output logic            busy,
    bbs_rng_stream_if.slave bus
);

    localparam int WORD_ITERS = word_iters(OUT_BITS, BITS_PER_ITER);
    localparam int CW         = $clog2(WORD_ITERS + 1);
    localparam logic [CW-1:0]     CNT_FULL = CW'(WORD_ITERS);
    localparam logic [N_BITS-1:0] MOD_N    = N_BITS'(MODULUS);

    if (N_BITS < 2 || N_BITS > 31) begin : g_bad_width
        $error("bbs_rng_stream: N_BITS out of range");
    end
    if (MODULUS >= (1 << N_BITS)) begin : g_bad_modulus
        $error("bbs_rng_stream: MODULUS does not fit in N_BITS");
    end
    if (BITS_PER_ITER < 1 || BITS_PER_ITER > 4 || (OUT_BITS % BITS_PER_ITER) != 0) begin : g_bad_pack
        $error("bbs_rng_stream: OUT_BITS must be a multiple of BITS_PER_ITER (1..4)");
    end

    bbs_state_t          state_q, state_d;
    logic [N_BITS-1:0]   x_q;
    logic [OUT_BITS-1:0] col_q;
    logic [CW-1:0]       cnt_q;
    logic [OUT_BITS-1:0] rnd_data_q;
    logic                rnd_valid_q;
    logic                seed_err_q;

    logic                sq_start;
    logic                sq_done;
    logic [N_BITS-1:0]   sq_result;

    logic [OUT_BITS-1:0] col_next;
    logic [CW-1:0]       cnt_next;
    logic                seed_acc;
    logic                seed_bad;
    logic                out_free;
    logic                stalled;
    logic                load_from_sq;
    logic                load_from_hold;

    bbs_modsq_serial #(
        .N_BITS  (N_BITS),
        .MODULUS (MODULUS)
    ) u_modsq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (sq_start),
        .a       (x_q),
        .busy    (busy),
        .done    (sq_done),
        .result  (sq_result)
    );

    always_comb begin
        state_d  = state_q;
        sq_start = 1'b0;
        seed_acc = 1'b0;

        out_free = !rnd_valid_q || bus.rnd_ready;
        stalled  = (cnt_q == CNT_FULL) && rnd_valid_q;
        seed_bad = (bus.seed <= N_BITS'(1)) || (bus.seed >= MOD_N);
        col_next = (col_q << BITS_PER_ITER) | OUT_BITS'(sq_result[BITS_PER_ITER-1:0]);
        cnt_next = cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                if (bus.seed_valid) begin
                    seed_acc = 1'b1;
                end else if (enable && !stalled) begin
                    sq_start = 1'b1;
                    state_d  = ST_SQ;
                end
            end
            ST_SQ: begin
                if (sq_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A full collector drains either straight from the finishing squaring or,
        // after backpressure, from the held copy once the output register frees up.
        load_from_sq   = sq_done && (cnt_next == CNT_FULL) && out_free;
        load_from_hold = (state_q == ST_IDLE) && !seed_acc && (cnt_q == CNT_FULL) && out_free;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= N_BITS'(DEFAULT_SEED);
            col_q       <= '0;
            cnt_q       <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_err_q <= seed_acc && seed_bad;

            if (seed_acc) begin
                if (!seed_bad) begin
                    x_q   <= bus.seed;
                    col_q <= '0;
                    cnt_q <= '0;
                end
            end else if (sq_done) begin
                x_q   <= sq_result;
                col_q <= load_from_sq ? '0 : col_next;
                cnt_q <= load_from_sq ? '0 : cnt_next;
            end else if (load_from_hold) begin
                col_q <= '0;
                cnt_q <= '0;
            end

            if (load_from_sq) begin
                rnd_data_q  <= col_next;
                rnd_valid_q <= 1'b1;
            end else if (load_from_hold) begin
                rnd_data_q  <= col_q;
                rnd_valid_q <= 1'b1;
            end else if (rnd_valid_q && bus.rnd_ready) begin
                rnd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.seed_ready = (state_q == ST_IDLE);
    assign bus.seed_err   = seed_err_q;
    assign bus.rnd_valid  = rnd_valid_q;
    assign bus.rnd_data   = rnd_data_q;

endmodule

// File: doc/bbs_rng_stream.md
Name: bbs_rng_stream

Overview:
- Parametrised Blum Blum Shub generator; next generation of the team's fixed 8-bit BBS block.
- Computes x <= x*x mod MODULUS with a bit-serial interleaved modular multiplier, so there is no wide combinational multiply.
- Extracts BITS_PER_ITER LSBs per squaring, packs them into OUT_BITS words and delivers words on a valid/ready stream.
- Seed loading is runtime, with a handshake and validation; sits between system control and any consumer of random words.

Parameters:
- N_BITS, 20, state/modulus width; must satisfy MODULUS < 2**N_BITS.
- MODULUS, 272953, Blum integer p*q (499*547, both ≡3 mod 4).
- OUT_BITS, 8, width of each output word; must be a multiple of BITS_PER_ITER.
- BITS_PER_ITER, 1, LSBs harvested per squaring (1..4).
- DEFAULT_SEED, 3, state loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run generator; when low, no new squaring starts (an in-flight one completes).
- seed_valid  in  1  seed offer.
- seed_ready  out  1  high only in IDLE.
- seed  in  N_BITS  seed value.
- seed_err  out  1  one-cycle pulse: seed rejected.
- rnd_valid  out  1  output word valid.
- rnd_ready  in  1  consumer accepts word.
- rnd_data  out  OUT_BITS  random word.
- busy  out  1  high in SQ state.

Behaviour:
- Reset (async, reset_n=0):
  - x=DEFAULT_SEED; collector=0; count=0.
  - rnd_valid=0, rnd_data=0, seed_err=0, busy=0, FSM=IDLE.
- FSM states IDLE, SQ.
- IDLE, evaluated in priority order:
  - seed_valid=1 (handshake completes since seed_ready=1):
    - seed ∈ {0,1} or seed>=MODULUS → seed_err pulses 1 cycle; x and collector unchanged.
    - Otherwise x<=seed, collector and count cleared.
    - Output register untouched in both cases.
  - Else enable=1 and not stalled → load multiplier (r=0, multiplicand=x, bit index=N_BITS-1), go to SQ.
- SQ: exactly N_BITS cycles, scanning x from MSB to LSB. Each cycle:
  - r' = 2r; if r'>=MODULUS then r'-=MODULUS.
  - If x[i]: r' += x; if r'>=MODULUS then r'-=MODULUS.
  - Internal datapath width N_BITS+1 with no overflow.
- End of SQ (last cycle):
  - x<=r_final.
  - collector <= {collector, r_final[BITS_PER_ITER-1:0]} (shift left; earliest bits end in the MSBs).
  - count++ ; return to IDLE.
- Timing: one squaring occupies N_BITS+1 cycles (1 IDLE + N_BITS SQ). seed_valid is not sampled during SQ.
- Word complete (count == OUT_BITS/BITS_PER_ITER), same cycle the last squaring ends:
  - If the output register is empty or being drained (rnd_valid & rnd_ready): rnd_data<=collector, rnd_valid<=1, count<=0.
  - Else the collector holds; "stalled" = collector full and rnd_valid=1. IDLE does not start a squaring while stalled.
  - When the stall clears, the collector transfers on the cycle after rnd_ready.
- Output register (double buffering):
  - rnd_valid drops the cycle after rnd_valid&rnd_ready, unless a new word loads in that same cycle.
  - rnd_data is stable while rnd_valid=1 and rnd_ready=0.
- Throughput without backpressure: one word per (OUT_BITS/BITS_PER_ITER)*(N_BITS+1) cycles.
- enable dropped mid-SQ: the squaring completes and its bits are kept. Idle cycles do not change x.
- x never reaches 0 for a valid seed coprime to MODULUS; coprimality (beyond 0/1/range) is the caller's duty.
- An accepted seed during a stall clears the collector; the held rnd_data is still delivered.

Decomposition:
- Package bbs_pkg:
  - FSM state enum.
  - Function mod_add_sub (conditional-subtract reduction).
  - Localparam WORD_ITERS = OUT_BITS/BITS_PER_ITER.
  - Elaboration checks on MODULUS < 2**N_BITS and OUT_BITS % BITS_PER_ITER == 0.
- Sub-module bbs_modsq_serial: start/done handshake, computes a*a mod MODULUS in N_BITS cycles. The top holds the FSM, collector and output buffer.

Test Plan:
- N_BITS=8, MODULUS=209, reset, enable=1, rnd_ready=1:
  - Successive x values are 9,81,82,36,42,92,104,157.
  - First rnd_data=0xC1; rnd_valid rises 72 cycles after enable.
- Seed handshake:
  - seed=0, then 209, then 1 → three seed_err pulses; x remains 3.
  - seed=4 → next x=16.
- Backpressure:
  - Hold rnd_ready=0 for 300 cycles → rnd_data frozen at 0xC1; busy=0 once the second word is collected.
  - Release rnd_ready → second word follows, with no bits lost or duplicated versus the golden model.
- reset_n asserted mid-SQ (cycle 4 of a squaring) → all outputs reset immediately; after release the sequence restarts from 9.
- BITS_PER_ITER=2, OUT_BITS=8 → word formed from 4 squarings. Default params: 1000 words match a golden software BBS model.
- enable toggled low mid-SQ → squaring finishes; no new start while low; sequence continuity preserved.
